// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the EX/MEM boundary: control bundle, registered entry, occupancy states.
// No logic state; pure typedefs, constants and the branch-taken helper.
// Optional CBNZ resolution (EX_MEM_CBNZ_EN) uses the helper's cbnz argument.
package ex_mem_stage_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  // Decoded execute-stage control bits.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic uncond;
  } ctl_t;

  // What the memory stage sees for one instruction.
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
  } entry_t;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // B always redirects; CBZ on zero; CBNZ on non-zero (tie cbnz low when unsupported).
  function automatic logic branch_taken(input ctl_t c, input logic zero, input logic cbnz);
    return c.uncond | (c.branch & zero) | (cbnz & ~zero);
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bundle of the execute-side inputs and memory-side outputs of the EX/MEM stage.
// slave = the stage itself, master = whoever drives execute and consumes memory side.
// ctl_cbnz exists only when EX_MEM_CBNZ_EN is defined.
interface ex_mem_stage_if;
  import ex_mem_stage_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] branch_target;
  logic [REG_W-1:0]  rd;
  logic              ctl_mem_read;
  logic              ctl_mem_write;
  logic              ctl_reg_write;
  logic              ctl_mem_to_reg;
  logic              ctl_branch;
  logic              ctl_uncond;
`ifdef EX_MEM_CBNZ_EN
  logic              ctl_cbnz;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [REG_W-1:0]  m_rd;
  logic              m_mem_read;
  logic              m_mem_write;
  logic              m_reg_write;
  logic              m_mem_to_reg;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;

  modport slave (
`ifdef EX_MEM_CBNZ_EN
    input  ctl_cbnz,
`endif
    input  flush, in_valid, alu_result, alu_zero, store_data, branch_target, rd,
    input  ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg, ctl_branch, ctl_uncond,
    input  out_ready,
    output in_ready, out_valid, m_addr, m_wdata, m_rd,
    output m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg,
    output redirect_valid, redirect_pc
  );

  modport master (
`ifdef EX_MEM_CBNZ_EN
    output ctl_cbnz,
`endif
    output flush, in_valid, alu_result, alu_zero, store_data, branch_target, rd,
    output ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg, ctl_branch, ctl_uncond,
    output out_ready,
    input  in_ready, out_valid, m_addr, m_wdata, m_rd,
    input  m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg,
    input  redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ex_mem_stage_skid_buffer.sv
// Generic 2-entry valid/ready register: main slot drives outputs, skid slot absorbs one extra.
// Latency: entry accepted at edge N is on o_data after edge N.
// Backpressure: o_ready is a register (low only when both slots full); no path from i_ready.
module ex_mem_stage_skid_buffer
  import ex_mem_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  skid_state_t r_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         w_accept;
  logic         w_emit;

  assign w_accept = i_valid & r_in_ready;
  assign w_emit   = r_out_valid & i_ready;

  // Occupancy FSM; flush wins over any accept/emit, data slots simply hold on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SKID_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (i_flush) begin
      r_state     <= SKID_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            r_main      <= i_data;
            r_state     <= SKID_ONE;
            r_out_valid <= 1'b1;
          end
        end
        SKID_ONE: begin
          if (w_accept && w_emit) begin
            r_main <= i_data;
          end else if (w_accept) begin
            r_skid     <= i_data;
            r_state    <= SKID_TWO;
            r_in_ready <= 1'b0;
          end else if (w_emit) begin
            r_state     <= SKID_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        SKID_TWO: begin
          if (w_emit) begin
            r_main     <= r_skid;
            r_state    <= SKID_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= SKID_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_main;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches ALU result + control, resolves B/CBZ (and CBNZ if EX_MEM_CBNZ_EN).
// Latency: 1 cycle to m_* outputs; redirect pulses the cycle after the branch is accepted.
// Backpressure: 2-entry skid buffer, in_ready registered; redirect fires regardless of out_ready.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  ex_mem_stage_if.slave bus
);

  ctl_t              w_ctl;
  entry_t            w_in_entry;
  entry_t            w_out_entry;
  logic              w_cbnz;
  logic              w_taken;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              r_redirect_valid;
  logic [DATA_W-1:0] r_redirect_pc;

  assign w_ctl = '{
    mem_read:   bus.ctl_mem_read,
    mem_write:  bus.ctl_mem_write,
    reg_write:  bus.ctl_reg_write,
    mem_to_reg: bus.ctl_mem_to_reg,
    branch:     bus.ctl_branch,
    uncond:     bus.ctl_uncond
  };

`ifdef EX_MEM_CBNZ_EN
  assign w_cbnz = bus.ctl_cbnz;
`else
  assign w_cbnz = 1'b0;
`endif

  assign w_taken  = branch_taken(w_ctl, bus.alu_zero, w_cbnz);
  // Same acceptance condition the skid buffer applies internally; flush drops the input.
  assign w_accept = bus.in_valid & w_in_ready & ~bus.flush;

  assign w_in_entry = '{
    addr:       bus.alu_result,
    wdata:      bus.store_data,
    rd:         bus.rd,
    mem_read:   w_ctl.mem_read,
    mem_write:  w_ctl.mem_write,
    reg_write:  w_ctl.reg_write,
    mem_to_reg: w_ctl.mem_to_reg
  };

  ex_mem_stage_skid_buffer #(
    .W($bits(entry_t))
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.flush),
    .i_valid (bus.in_valid),
    .o_ready (w_in_ready),
    .i_data  (w_in_entry),
    .o_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_out_entry)
  );

  // One-cycle redirect pulse for a taken branch accepted this edge; target held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_accept & w_taken;
      if (w_accept && w_taken) begin
        r_redirect_pc <= bus.branch_target;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.m_addr         = w_out_entry.addr;
  assign bus.m_wdata        = w_out_entry.wdata;
  assign bus.m_rd           = w_out_entry.rd;
  assign bus.m_mem_read     = w_out_entry.mem_read;
  assign bus.m_mem_write    = w_out_entry.mem_write;
  assign bus.m_reg_write    = w_out_entry.reg_write;
  assign bus.m_mem_to_reg   = w_out_entry.mem_to_reg;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed cases followed by random traffic against a queue-based model.
// Inputs change on the falling edge; outputs are examined 2 time units after it.
// CBNZ cases are built only when EX_MEM_CBNZ_EN is defined.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_stage_if bus();

  ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam ctl_t C_NONE = '{0, 0, 0, 0, 0, 0};
  localparam ctl_t C_ADD  = '{0, 0, 1, 0, 0, 0};
  localparam ctl_t C_LDUR = '{1, 0, 1, 1, 0, 0};
  localparam ctl_t C_STUR = '{0, 1, 0, 0, 0, 0};
  localparam ctl_t C_CBZ  = '{0, 0, 0, 0, 1, 0};
  localparam ctl_t C_B    = '{0, 0, 0, 0, 0, 1};

  int checks = 0;
  int passed = 0;
  int n_emitted = 0;
  int base_emit;
  int occ;
  entry_t exp_q[$];
  logic exp_redir = 1'b0;
  logic [63:0] exp_redir_pc = '0;
  logic model_rdy = 1'b1;
  logic run_chk = 1'b0;
  logic acc_m;
  logic cb_now;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference rule written as a decision list.
  function automatic logic ref_taken(input ctl_t c, input logic zero, input logic cbnz);
    if (c.uncond) return 1'b1;
    if (c.branch && zero) return 1'b1;
    if (cbnz && !zero) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic v, input logic [63:0] res, input logic z, input logic [63:0] tgt,
                       input logic [4:0] r, input ctl_t c, input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid       = v;
    bus.alu_result     = res;
    bus.alu_zero       = z;
    bus.store_data     = {$urandom, $urandom};
    bus.branch_target  = tgt;
    bus.rd             = r;
    bus.ctl_mem_read   = c.mem_read;
    bus.ctl_mem_write  = c.mem_write;
    bus.ctl_reg_write  = c.reg_write;
    bus.ctl_mem_to_reg = c.mem_to_reg;
    bus.ctl_branch     = c.branch;
    bus.ctl_uncond     = c.uncond;
`ifdef EX_MEM_CBNZ_EN
    bus.ctl_cbnz       = 1'b0;
`endif
    bus.out_ready      = ordy;
    bus.flush          = fl;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 64'h0, 1'b0, 64'h0, 5'd0, C_NONE, ordy, 1'b0);
  endtask

  // Predictor: at each edge decide what the stage accepted and what redirect follows.
  initial forever begin
    @(posedge clk);
    if (run_chk && rst_n) begin
`ifdef EX_MEM_CBNZ_EN
      cb_now = bus.ctl_cbnz;
`else
      cb_now = 1'b0;
`endif
      acc_m = bus.in_valid && model_rdy && !bus.flush;
      if (bus.flush) exp_q.delete();
      if (acc_m) exp_q.push_back('{bus.alu_result, bus.store_data, bus.rd, bus.ctl_mem_read,
                                   bus.ctl_mem_write, bus.ctl_reg_write, bus.ctl_mem_to_reg});
      exp_redir = acc_m && ref_taken('{bus.ctl_mem_read, bus.ctl_mem_write, bus.ctl_reg_write,
                                       bus.ctl_mem_to_reg, bus.ctl_branch, bus.ctl_uncond},
                                     bus.alu_zero, cb_now);
      if (exp_redir) exp_redir_pc = bus.branch_target;
    end
  end

  // Monitor: compare outputs with the model head, retire the head on a handshake.
  initial forever begin
    @(negedge clk);
    #2;
    if (run_chk && rst_n) begin
      occ = exp_q.size();
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, occ > 0});
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, occ < 2});
      chk("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, exp_redir});
      if (exp_redir) chk("redirect_pc", bus.redirect_pc, exp_redir_pc);
      if (occ > 0 && bus.out_valid) begin
        chk("m_addr", bus.m_addr, exp_q[0].addr);
        chk("m_wdata", bus.m_wdata, exp_q[0].wdata);
        chk("m_rd", {59'd0, bus.m_rd}, {59'd0, exp_q[0].rd});
        chk("m_flags", {60'd0, bus.m_mem_read, bus.m_mem_write, bus.m_reg_write, bus.m_mem_to_reg},
            {60'd0, exp_q[0].mem_read, exp_q[0].mem_write, exp_q[0].reg_write, exp_q[0].mem_to_reg});
      end
      model_rdy = (occ < 2);
      if (occ > 0 && bus.out_ready) begin
        void'(exp_q.pop_front());
        n_emitted++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    chk({tag, "_redirect_valid"}, {63'd0, bus.redirect_valid}, 64'd0);
    chk({tag, "_redirect_pc"}, bus.redirect_pc, 64'd0);
    chk({tag, "_m_addr"}, bus.m_addr, 64'd0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 64'd0);
    chk({tag, "_m_rd_flags"}, {55'd0, bus.m_rd, bus.m_mem_read, bus.m_mem_write,
                               bus.m_reg_write, bus.m_mem_to_reg}, 64'd0);
  endtask

  logic [31:0] rb;
  ctl_t rc;

  initial begin
    idle(1'b0, 1);
    @(negedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n   = 1'b1;
    run_chk = 1'b1;

    // Single ADD.
    drive(1'b1, 64'h10, 1'b0, 64'h0, 5'd3, C_ADD, 1'b1, 1'b0);
    idle(1'b1, 3);

    // A, B held with out_ready low, C waits, then everything drains in order.
    base_emit = n_emitted;
    drive(1'b1, 64'hA0, 1'b0, 64'h0, 5'd1, C_LDUR, 1'b0, 1'b0);
    drive(1'b1, 64'hB0, 1'b0, 64'h0, 5'd2, C_STUR, 1'b0, 1'b0);
    drive(1'b1, 64'hC0, 1'b0, 64'h0, 5'd4, C_ADD, 1'b0, 1'b0);
    drive(1'b1, 64'hC0, 1'b0, 64'h0, 5'd4, C_ADD, 1'b1, 1'b0);
    drive(1'b1, 64'hC0, 1'b0, 64'h0, 5'd4, C_ADD, 1'b1, 1'b0);
    idle(1'b1, 3);
    chk("abc_emitted", n_emitted - base_emit, 64'd3);

    // CBZ taken then not taken.
    drive(1'b1, 64'h0, 1'b1, 64'h400, 5'd0, C_CBZ, 1'b1, 1'b0);
    idle(1'b1, 3);
    drive(1'b1, 64'h5, 1'b0, 64'h500, 5'd0, C_CBZ, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Flush while full with a taken branch presented.
    drive(1'b1, 64'h11, 1'b0, 64'h0, 5'd5, C_ADD, 1'b0, 1'b0);
    drive(1'b1, 64'h22, 1'b0, 64'h0, 5'd6, C_ADD, 1'b0, 1'b0);
    drive(1'b1, 64'h33, 1'b1, 64'h900, 5'd0, C_B, 1'b0, 1'b1);
    idle(1'b1, 3);

`ifdef EX_MEM_CBNZ_EN
    drive(1'b1, 64'h7, 1'b0, 64'h88, 5'd0, C_NONE, 1'b1, 1'b0);
    bus.ctl_cbnz = 1'b1;
    idle(1'b1, 3);
    drive(1'b1, 64'h0, 1'b1, 64'h99, 5'd0, C_NONE, 1'b1, 1'b0);
    bus.ctl_cbnz = 1'b1;
    idle(1'b1, 3);
`endif

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rb = $urandom;
      rc = rb[5:0];
      rc.uncond = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
            {$urandom, $urandom}, 5'($urandom), rc, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
`ifdef EX_MEM_CBNZ_EN
      if (!rc.branch) bus.ctl_cbnz = ($urandom_range(0, 3) == 0);
`endif
    end
    idle(1'b1, 3);

    // Asynchronous reset while full with a redirect pending.
    drive(1'b1, 64'h44, 1'b0, 64'h0, 5'd7, C_ADD, 1'b0, 1'b0);
    drive(1'b1, 64'h55, 1'b0, 64'h123, 5'd0, C_B, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    run_chk = 1'b0;
    chk("pre_reset_redirect", {63'd0, bus.redirect_valid}, {63'd0, exp_redir});
    chk("pre_reset_full", {63'd0, bus.in_ready}, {63'd0, exp_q.size() < 2});
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    exp_redir = 1'b0;
    model_rdy = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    run_chk = 1'b1;
    drive(1'b1, 64'h66, 1'b0, 64'h0, 5'd8, C_ADD, 1'b1, 1'b0);
    idle(1'b1, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the 64-bit ALU: registers the ALU result and zero flag together with the execute-stage control bits into the EX/MEM boundary.
- Resolves CBZ and unconditional branches from the zero flag and issues a one-cycle PC redirect.
- Uses a valid/ready handshake with a 2-entry skid buffer, so memory-stage back-pressure never combinationally reaches the execute stage.

Parameters:
- DATA_W, 64, width of ALU result, store data and branch target
- REG_W, 5, destination register index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  execute stage presents an entry
- in_ready  out  1  stage can accept this cycle
- alu_result  in  DATA_W  ALU output
- alu_zero  in  1  ALU zero flag
- store_data  in  DATA_W  second register operand (for STUR)
- branch_target  in  DATA_W  precomputed PC + offset
- rd  in  REG_W  destination register
- ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg, ctl_branch, ctl_uncond  in  1 each  decoded control
- out_valid  out  1  entry available to memory stage
- out_ready  in  1  memory stage accepts
- m_addr  out  DATA_W  registered alu_result
- m_wdata  out  DATA_W  registered store_data
- m_rd  out  REG_W
- m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg  out  1 each
- redirect_valid  out  1  one-cycle pulse: branch taken
- redirect_pc  out  DATA_W  target for fetch

Behaviour:
- Reset (rst_n low, asynchronous): both entries invalid.
  - out_valid=0, in_ready=1, redirect_valid=0.
  - All data outputs and redirect_pc = 0.
- Transfers:
  - Accept occurs when in_valid && in_ready at the rising edge.
  - Emit occurs when out_valid && out_ready.
  - Latency: entry accepted at edge N is visible on the m_* outputs after edge N.
- Storage: main register (drives outputs) plus a skid register.
  - in_ready = !skid_valid (registered; no combinational path from out_ready).
- State machine, named by occupancy:
  - EMPTY: accept -> ONE.
  - ONE, with accept and emit -> ONE (main reloaded from input).
  - ONE, with accept and no emit -> TWO (input goes to skid).
  - ONE, with emit and no accept -> EMPTY.
  - TWO: in_ready=0. On emit, skid moves to main -> ONE.
- Branch resolution is evaluated on the input side at accept:
  - taken = ctl_uncond | (ctl_branch & alu_zero).
  - When taken, the next cycle has redirect_valid=1 and redirect_pc=branch_target, for exactly one cycle.
  - A redirect is independent of out_ready: it fires even if the entry then waits in the skid.
  - A branch entry still flows to MEM with its m_* write/read bits as decoded (normally all 0).
- Flush:
  - Clears main and skid valid at the edge.
  - Blocks acceptance that cycle: an in_valid entry presented with flush is dropped, with no redirect.
  - A redirect already registered still pulses; flush is not retroactive.
- Simultaneous events:
  - flush has priority over accept and emit.
  - Reset mid-operation discards everything immediately, including an in-flight redirect pulse.
- Data outputs hold their last value while out_valid=0. The verifier checks them only when out_valid=1.
- Inputs are sampled at the clock edge. The ALU settles within the cycle, and its output is treated as stable at the edge.

Optional Feature:
- Macro: EX_MEM_CBNZ_EN.
- Defined:
  - Adds input ctl_cbnz (1 bit).
  - taken = ctl_uncond | (ctl_branch & alu_zero) | (ctl_cbnz & !alu_zero).
  - ctl_cbnz and ctl_branch are never both 1. If they are, taken follows the OR above.
- Undefined: the port is absent and only CBZ/B are resolved.

Decomposition:
- Shared package:
  - A control-bundle typedef with the six ctl bits.
  - The EX/MEM entry typedef: addr, wdata, rd and the four mem/wb bits.
  - Constants DATA_W=64, REG_W=5.
- One natural sub-module: skid_buffer, a generic 2-entry valid/ready register parameterised on payload width. It holds the entry typedef.
- Branch resolution and the redirect register stay in ex_mem_stage.

Test Plan:
- Reset, then single ADD entry (alu_result=0x10, rd=3, reg_write=1) with out_ready=1 -> next cycle out_valid=1, m_addr=0x10, m_rd=3; following cycle out_valid=0.
- out_ready=0, three back-to-back entries A, B, C -> A in main, B in skid, in_ready=0 so C is held. Raise out_ready -> A, B, C emitted in order with no loss or duplication.
- CBZ accepted with alu_zero=1, branch_target=0x400 -> one cycle later redirect_valid=1, redirect_pc=0x400, for exactly one cycle. Same with alu_zero=0 -> no redirect.
- Stage in TWO state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no redirect, flushed entries never appear.
- Deassert rst_n asynchronously between edges while in TWO with a redirect pending -> outputs immediately zero, out_valid=0, redirect_valid=0.
- With EX_MEM_CBNZ_EN: ctl_cbnz=1, alu_zero=0, target=0x88 -> redirect to 0x88. ctl_cbnz=1, alu_zero=1 -> no redirect.
